trace_stream_arbiter: RTL and testbench
=======================================

Name: trace_stream_arbiter

Overview:
- Shares one character-stream format checker between two trace producers (s0, s1), e.g. two CPU cores emitting "^time@pc: $grf <= data#" / "^time@pc: *addr <= data#" records.
- Grants the checker lane for a whole record, from grant until '#'. Selection is round-robin between the two producers.
- Feeds characters to the checker and samples the checker's format_type result. Reports one tagged result per record and keeps per-source ok/error counters.
- Aborts records that stall or overrun.

Parameters:
MAX_LEN, 64, max characters forwarded per grant before forced abort (>=2)
CNT_W, 8, width of each saturating result counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
s0_valid  input  1  source 0 has a character on s0_char
s0_char  input  8  source 0 character
s0_ready  output  1  source 0 character consumed this cycle
s1_valid  input  1  source 1 valid
s1_char  input  8  source 1 character
s1_ready  output  1  source 1 consumed
chk_char  output  8  character driven to the checker every cycle
chk_fire  output  1  chk_char carries a real source character
chk_format_type  input  2  checker result: 00 error/none, 01 register, 10 storage
rec_done  output  1  one-cycle pulse: record result valid
rec_owner  output  1  source of the reported record
rec_type  output  2  result of the reported record (00 if aborted)
rec_abort  output  1  reported record was aborted
ok_cnt0  output  CNT_W  source 0 records with rec_type != 00
err_cnt0  output  CNT_W  source 0 records with rec_type == 00
ok_cnt1  output  CNT_W
err_cnt1  output  CNT_W

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk. All state changes on posedge clk.
- The checker has no stall input; it consumes chk_char every cycle. Filler character is 8'h00 (not '^'); it returns the checker to its start state.
- chk_char and chk_fire are combinational:
  - In XFER with s_valid[owner]=1: chk_char = s_char[owner], chk_fire = 1.
  - Otherwise: chk_char = 8'h00, chk_fire = 0.
- s_ready[i] = (state==XFER && owner==i). Data is accepted when valid && ready.
- FSM states: IDLE, XFER, RESULT.
- IDLE:
  - If any s_valid is high: choose owner, clear len, go to XFER. No character is accepted in the IDLE cycle.
  - Owner choice: if both valid, the source != last_owner wins; otherwise the single valid source wins.
- XFER, each cycle:
  - Accepted character == "#": go to RESULT, aborted=0.
  - s_valid[owner]==0 (gap): go to RESULT, aborted=1. The 00 filler has already been sent.
  - Accepted non-'#' character with len+1 == MAX_LEN: go to RESULT, aborted=1.
  - Otherwise len <= len+1.
  - A mid-record '^' is forwarded unchanged.
- RESULT (one cycle):
  - chk_format_type now reflects the character sent the previous cycle.
  - Register rec_owner=owner, rec_type = aborted ? 00 : chk_format_type, rec_abort=aborted.
  - Update the counters, set last_owner=owner, go to IDLE.
  - rec_done=1 in the following cycle only (registered pulse, coincident with IDLE).
- Latency: '#' on chk_char at cycle t; result sampled at t+1; rec_done at t+2. The earliest next grant decision is also at t+2 (IDLE); the next character is accepted at t+3.
- Counters: increment the counter selected by owner and result, saturating at all-ones with no wrap. Exactly one counter changes per record.
- Reset (any state, including mid-record):
  - state=IDLE, readies 0, chk_char 00, rec_done/rec_abort 0, rec_type 00, rec_owner 0, counters 0.
  - last_owner=1, so s0 wins the first tie.
- Simultaneous events: a source whose valid rises while the other holds the grant waits. A grant is never pre-empted.

Test Plan:
- s0 sends "^10@00003000: $1 <= 0000000a#" with valid held: one IDLE cycle, then 29 chars with chk_fire=1. rec_done 2 cycles after '#': rec_owner=0, rec_type=01, rec_abort=0, ok_cnt0=1.
- s1 sends "^5@00003004: *00000010 <= 12345678#" -> rec_type=10, ok_cnt1=1. Malformed "^5@3004: $1 <= 1#" -> rec_type=00, err_cnt1=1.
- Both valid from reset, each sending 3 valid records -> grant order s0,s1,s0,s1,s0,s1. No character from the non-owner is accepted.
- s0 drops valid for one cycle mid-record -> chk_char=00 that cycle, rec_abort=1, rec_type=00, err_cnt0 +1. The next grant goes to s1 if s1 is waiting.
- MAX_LEN=8, s0 streams 20 chars with no '#' -> exactly 8 chars forwarded, then abort, rec_type=00. The remaining chars are delivered in later grants.
- CNT_W=2: 5 good s0 records -> ok_cnt0 stays 3. Reset asserted mid-XFER -> next cycle IDLE, all counters 0, no rec_done.

Source files
------------

// File: rtl/trace_stream_arbiter.sv
// trace_stream_arbiter: shares one trace format checker between two
// character producers, round-robin, one whole record per grant.
module trace_stream_arbiter #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s0_valid,
  input  logic [7:0]       s0_char,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [7:0]       s1_char,
  output logic             s1_ready,
  output logic [7:0]       chk_char,
  output logic             chk_fire,
  input  logic [1:0]       chk_format_type,
  output logic             rec_done,
  output logic             rec_owner,
  output logic [1:0]       rec_type,
  output logic             rec_abort,
  output logic [CNT_W-1:0] ok_cnt0,
  output logic [CNT_W-1:0] err_cnt0,
  output logic [CNT_W-1:0] ok_cnt1,
  output logic [CNT_W-1:0] err_cnt1
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0] END_CH = 8'h23;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESULT
  } state_t;

  state_t           state;
  logic             owner;
  logic             last_owner;
  logic             aborted;
  logic [LEN_W-1:0] len;

  logic             own_valid;
  logic [7:0]       own_char;
  logic [1:0]       res_type;
  logic             res_ok;

  assign own_valid = owner ? s1_valid : s0_valid;
  assign own_char  = owner ? s1_char : s0_char;

  assign s0_ready = (state == XFER) && !owner;
  assign s1_ready = (state == XFER) && owner;

  // Filler 00 returns the checker to its start state
  assign chk_fire = (state == XFER) && own_valid;
  assign chk_char = chk_fire ? own_char : 8'h00;

  assign res_type = aborted ? 2'b00 : chk_format_type;
  assign res_ok   = (res_type != 2'b00);

  // Grant / transfer / result FSM with registered report and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      aborted    <= 1'b0;
      len        <= '0;
      rec_done   <= 1'b0;
      rec_owner  <= 1'b0;
      rec_type   <= 2'b00;
      rec_abort  <= 1'b0;
      ok_cnt0    <= '0;
      err_cnt0   <= '0;
      ok_cnt1    <= '0;
      err_cnt1   <= '0;
    end else begin
      rec_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            owner   <= (s0_valid && s1_valid) ? ~last_owner : s1_valid;
            len     <= '0;
            aborted <= 1'b0;
            state   <= XFER;
          end
        end
        XFER: begin
          if (!own_valid) begin
            aborted <= 1'b1;
            state   <= RESULT;
          end else if (own_char == END_CH) begin
            aborted <= 1'b0;
            state   <= RESULT;
          end else if (len == LAST_IDX) begin
            aborted <= 1'b1;
            state   <= RESULT;
          end else begin
            len <= len + LEN_ONE;
          end
        end
        RESULT: begin
          rec_done   <= 1'b1;
          rec_owner  <= owner;
          rec_type   <= res_type;
          rec_abort  <= aborted;
          last_owner <= owner;
          state      <= IDLE;
          unique case (1'b1)
            !owner && res_ok:
              if (ok_cnt0 != '1) ok_cnt0 <= ok_cnt0 + CNT_ONE;
            !owner && !res_ok:
              if (err_cnt0 != '1) err_cnt0 <= err_cnt0 + CNT_ONE;
            owner && res_ok:
              if (ok_cnt1 != '1) ok_cnt1 <= ok_cnt1 + CNT_ONE;
            owner && !res_ok:
              if (err_cnt1 != '1) err_cnt1 <= err_cnt1 + CNT_ONE;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// tb_trace_stream_arbiter: queue-driven sources, stand-in checker and
// a record-level round-robin model for trace_stream_arbiter.
module tb_trace_stream_arbiter;

  localparam int MAX_LEN = 40;
  localparam int CNT_W = 3;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam logic [8:0] GAP = 9'h100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s0_valid = 1'b0, s1_valid = 1'b0;
  logic [7:0] s0_char = 8'h00, s1_char = 8'h00;
  logic s0_ready, s1_ready;
  logic [7:0] chk_char;
  logic chk_fire;
  logic [1:0] chk_format_type = 2'b00;
  logic rec_done, rec_owner, rec_abort;
  logic [1:0] rec_type;
  logic [CNT_W-1:0] ok_cnt0, err_cnt0, ok_cnt1, err_cnt1;

  int n_vec = 0;
  int n_err = 0;
  int first_fire;
  int mok0, merr0, mok1, merr1;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] chk_buf[$];

  logic       exp_owner[$];
  logic [1:0] exp_type[$];
  logic       exp_abort[$];
  logic       exp_gap[$];
  int         exp_len[$];
  logic [7:0] exp_chars[$];
  logic       exp_cown[$];

  trace_stream_arbiter #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_char(s0_char), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_char(s1_char), .s1_ready(s1_ready),
    .chk_char(chk_char), .chk_fire(chk_fire),
    .chk_format_type(chk_format_type),
    .rec_done(rec_done), .rec_owner(rec_owner),
    .rec_type(rec_type), .rec_abort(rec_abort),
    .ok_cnt0(ok_cnt0), .err_cnt0(err_cnt0),
    .ok_cnt1(ok_cnt1), .err_cnt1(err_cnt1)
  );

  always #5 clk = ~clk;

  // '^', 8-digit pc between '@' and ':', then " $" (01) or " *" (10)
  function automatic logic [1:0] classify(input logic [7:0] r[$]);
    int a = -1;
    int c = -1;
    if (r.size() < 4 || r[0] != "^") return 2'b00;
    for (int i = 0; i < r.size(); i++) begin
      if (r[i] == "@" && a < 0) a = i;
      if (r[i] == ":" && c < 0) c = i;
    end
    if (a < 0 || c < 0 || c - a - 1 != 8) return 2'b00;
    if (c + 2 >= r.size() || r[c+1] != " ") return 2'b00;
    if (r[c+2] == "$") return 2'b01;
    if (r[c+2] == "*") return 2'b10;
    return 2'b00;
  endfunction

  // Stand-in checker: result for '#' appears the cycle after it
  always @(posedge clk) begin
    if (reset) begin
      chk_format_type <= 2'b00;
      chk_buf.delete();
    end else if (chk_fire) begin
      chk_buf.push_back(chk_char);
      if (chk_char == 8'h23) begin
        chk_format_type <= classify(chk_buf);
        chk_buf.delete();
      end else begin
        chk_format_type <= 2'b00;
      end
    end else begin
      chk_buf.delete();
      chk_format_type <= 2'b00;
    end
  end

  function automatic void apply_inputs();
    s0_valid = (q0.size() > 0) && !q0[0][8];
    s1_valid = (q1.size() > 0) && !q1[0][8];
    s0_char = s0_valid ? q0[0][7:0] : 8'($urandom);
    s1_char = s1_valid ? q1[0][7:0] : 8'($urandom);
  endfunction

  task automatic push_str(input int src, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (src == 0) q0.push_back({1'b0, s[i]});
      else q1.push_back({1'b0, s[i]});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    apply_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mok0 = 0; merr0 = 0; mok1 = 0; merr1 = 0;
  endtask

  // Record-level model: round robin, whole record per grant
  task automatic build_model();
    logic [8:0] m0[$];
    logic [8:0] m1[$];
    logic [7:0] tmp[$];
    logic [8:0] e;
    logic last, own, v0, v1, ab, gp;
    logic [1:0] typ;
    m0 = q0; m1 = q1; last = 1'b1;
    exp_owner.delete(); exp_type.delete(); exp_abort.delete();
    exp_gap.delete(); exp_len.delete();
    exp_chars.delete(); exp_cown.delete();
    while (m0.size() > 0 || m1.size() > 0) begin
      v0 = (m0.size() > 0) && !m0[0][8];
      v1 = (m1.size() > 0) && !m1[0][8];
      if (!v0 && !v1) begin
        if (m0.size() > 0) void'(m0.pop_front());
        if (m1.size() > 0) void'(m1.pop_front());
        continue;
      end
      own = (v0 && v1) ? ~last : v1;
      tmp.delete(); ab = 1'b1; gp = 1'b0; typ = 2'b00;
      forever begin
        if ((own ? m1.size() : m0.size()) == 0) begin
          gp = 1'b1;
          break;
        end
        e = own ? m1.pop_front() : m0.pop_front();
        if (e[8]) begin
          gp = 1'b1;
          break;
        end
        tmp.push_back(e[7:0]);
        exp_chars.push_back(e[7:0]);
        exp_cown.push_back(own);
        if (e[7:0] == 8'h23) begin
          ab = 1'b0;
          typ = classify(tmp);
          break;
        end
        if (tmp.size() == MAX_LEN) break;
      end
      exp_owner.push_back(own); exp_type.push_back(typ);
      exp_abort.push_back(ab); exp_gap.push_back(gp);
      exp_len.push_back(tmp.size());
      last = own;
    end
  endtask

  task automatic run_stream(input int max_cycles);
    int cyc = 0;
    int rec_idx = 0;
    int ch_idx = 0;
    int last_fire = -100;
    int rec_chars = 0;
    int prev_done = -1;
    logic acc0, acc1;
    first_fire = -1;
    apply_inputs();
    while (rec_idx < exp_owner.size() && cyc < max_cycles) begin
      @(negedge clk);
      n_vec++;
      if (s0_ready && s1_ready) begin
        n_err++;
        $display("FAIL both_ready cyc=%0d got 1/1 need one-hot", cyc);
      end
      if (chk_fire) begin
        n_vec++;
        if (ch_idx >= exp_chars.size()) begin
          n_err++;
          $display("FAIL fwd_char cyc=%0d got %h, none expected", cyc, chk_char);
        end else if (chk_char !== exp_chars[ch_idx] ||
                     (exp_cown[ch_idx] ? s1_ready : s0_ready) !== 1'b1) begin
          n_err++;
          $display("FAIL fwd_char cyc=%0d got %h rdy=%b%b need %h from s%0d",
                   cyc, chk_char, s1_ready, s0_ready,
                   exp_chars[ch_idx], exp_cown[ch_idx]);
        end
        if (rec_chars == 0 && prev_done >= 0) begin
          n_vec++;
          if (cyc != prev_done + 1) begin
            n_err++;
            $display("FAIL grant_delay got cyc %0d need %0d", cyc, prev_done + 1);
          end
        end
        if (first_fire < 0) first_fire = cyc;
        ch_idx++; rec_chars++; last_fire = cyc;
      end else begin
        n_vec++;
        if (chk_char !== 8'h00) begin
          n_err++;
          $display("FAIL filler cyc=%0d got %h need 00", cyc, chk_char);
        end
      end
      if (rec_done) begin
        n_vec++;
        if ({rec_owner, rec_type, rec_abort} !==
            {exp_owner[rec_idx], exp_type[rec_idx], exp_abort[rec_idx]}) begin
          n_err++;
          $display("FAIL rec_result #%0d got own=%b typ=%b ab=%b need own=%b typ=%b ab=%b",
                   rec_idx, rec_owner, rec_type, rec_abort,
                   exp_owner[rec_idx], exp_type[rec_idx], exp_abort[rec_idx]);
        end
        n_vec++;
        if (rec_chars != exp_len[rec_idx]) begin
          n_err++;
          $display("FAIL rec_len #%0d got %0d need %0d", rec_idx, rec_chars, exp_len[rec_idx]);
        end
        n_vec++;
        if (cyc != last_fire + (exp_gap[rec_idx] ? 3 : 2)) begin
          n_err++;
          $display("FAIL rec_latency #%0d got cyc %0d, last char cyc %0d",
                   rec_idx, cyc, last_fire);
        end
        if (!exp_owner[rec_idx]) begin
          if (exp_type[rec_idx] != 2'b00) mok0 = (mok0 < CMAX) ? mok0 + 1 : mok0;
          else merr0 = (merr0 < CMAX) ? merr0 + 1 : merr0;
        end else begin
          if (exp_type[rec_idx] != 2'b00) mok1 = (mok1 < CMAX) ? mok1 + 1 : mok1;
          else merr1 = (merr1 < CMAX) ? merr1 + 1 : merr1;
        end
        n_vec++;
        if ({ok_cnt0, err_cnt0, ok_cnt1, err_cnt1} !==
            {CNT_W'(mok0), CNT_W'(merr0), CNT_W'(mok1), CNT_W'(merr1)}) begin
          n_err++;
          $display("FAIL counters #%0d got %0d/%0d/%0d/%0d need %0d/%0d/%0d/%0d",
                   rec_idx, ok_cnt0, err_cnt0, ok_cnt1, err_cnt1,
                   mok0, merr0, mok1, merr1);
        end
        rec_idx++; rec_chars = 0; prev_done = cyc;
      end
      acc0 = s0_valid && s0_ready;
      acc1 = s1_valid && s1_ready;
      @(posedge clk);
      #1;
      if (q0.size() > 0 && (acc0 || q0[0][8])) void'(q0.pop_front());
      if (q1.size() > 0 && (acc1 || q1[0][8])) void'(q1.pop_front());
      apply_inputs();
      cyc++;
    end
    n_vec++;
    if (rec_idx != exp_owner.size()) begin
      n_err++;
      $display("FAIL timeout got %0d records need %0d", rec_idx, exp_owner.size());
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (rec_done || chk_fire) begin
        n_err++;
        $display("FAIL idle_tail got done=%b fire=%b need 0/0", rec_done, chk_fire);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    push_str(0, "^1@00000000: $1 <= 1#");
    push_str(1, "^1@00000000: $1 <= 1#");
    apply_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({s0_ready, s1_ready, chk_fire, chk_char} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_io got rdy=%b%b fire=%b ch=%h need 0",
               s1_ready, s0_ready, chk_fire, chk_char);
    end
    n_vec++;
    if ({rec_done, rec_owner, rec_type, rec_abort} !== 5'd0) begin
      n_err++;
      $display("FAIL reset_rec got %b%b%b%b need 0", rec_done, rec_owner, rec_type, rec_abort);
    end
    n_vec++;
    if ({ok_cnt0, err_cnt0, ok_cnt1, err_cnt1} !== '0) begin
      n_err++;
      $display("FAIL reset_cnt got %0d/%0d/%0d/%0d need 0",
               ok_cnt0, err_cnt0, ok_cnt1, err_cnt1);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    push_str(0, "^10@00003000: $1 <= 0000000a#");
    build_model();
    run_stream(300);
    n_vec++;
    if (first_fire != 1) begin
      n_err++;
      $display("FAIL single_idle got first char cyc %0d need 1", first_fire);
    end
    n_vec++;
    if (ok_cnt0 !== CNT_W'(1) || err_cnt0 !== '0) begin
      n_err++;
      $display("FAIL single_cnt got ok=%0d err=%0d need 1/0", ok_cnt0, err_cnt0);
    end
  endtask

  task automatic test_s1_types();
    do_reset();
    push_str(1, "^5@00003004: *00000010 <= 12345678#");
    push_str(1, "^5@3004: $1 <= 1#");
    build_model();
    run_stream(300);
    n_vec++;
    if (ok_cnt1 !== CNT_W'(1) || err_cnt1 !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL s1_cnt got ok=%0d err=%0d need 1/1", ok_cnt1, err_cnt1);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_str(0, $sformatf("^%0d@0000300%0d: $2 <= 0000000%0d#", i, i, i));
      push_str(1, $sformatf("^%0d@0000400%0d: *00000020 <= 0000000%0d#", i, i, i));
    end
    build_model();
    run_stream(600);
    n_vec++;
    if (ok_cnt0 !== CNT_W'(3) || ok_cnt1 !== CNT_W'(3)) begin
      n_err++;
      $display("FAIL rr_cnt got %0d/%0d need 3/3", ok_cnt0, ok_cnt1);
    end
  endtask

  task automatic test_gap();
    do_reset();
    push_str(0, "^10@000");
    q0.push_back(GAP);
    push_str(0, "03000: $1 <= 0000000a#");
    push_str(1, "^7@00005000: $3 <= 00000003#");
    build_model();
    run_stream(400);
    n_vec++;
    if (err_cnt0 !== CNT_W'(2) || ok_cnt1 !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL gap_cnt got err0=%0d ok1=%0d need 2/1", err_cnt0, ok_cnt1);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 50; i++) q0.push_back({1'b0, 8'h61 + 8'(i % 6)});
    push_str(0, "#");
    build_model();
    run_stream(400);
    n_vec++;
    if (err_cnt0 !== CNT_W'(2) || ok_cnt0 !== '0) begin
      n_err++;
      $display("FAIL overrun_cnt got err0=%0d ok0=%0d need 2/0", err_cnt0, ok_cnt0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++)
      push_str(0, $sformatf("^%0d@00006000: $4 <= %08h#", i, i));
    build_model();
    run_stream(800);
    n_vec++;
    if (ok_cnt0 !== CNT_W'(CMAX)) begin
      n_err++;
      $display("FAIL sat_cnt got %0d need %0d", ok_cnt0, CMAX);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_str(0, "^1@00000100: $1 <= 00000001#");
    build_model();
    run_stream(200);
    push_str(0, "^2@00000200: $1 <= 00000002#");
    apply_inputs();
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (s0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_xfer got s0_ready=%b need 1", s0_ready);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({s0_ready, s1_ready, chk_fire, rec_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_reset got rdy0=%b rdy1=%b fire=%b done=%b need 0",
               s0_ready, s1_ready, chk_fire, rec_done);
    end
    n_vec++;
    if ({ok_cnt0, err_cnt0, ok_cnt1, err_cnt1} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_cnt got %0d/%0d/%0d/%0d need 0",
               ok_cnt0, err_cnt0, ok_cnt1, err_cnt1);
    end
    do_reset();
  endtask

  task automatic add_random_rec(input int src, input int kind);
    string s;
    int k;
    case (kind)
      0: s = $sformatf("^%0d@%08h: $%0d <= %08h#", $urandom_range(999),
                       $urandom, $urandom_range(31), $urandom);
      1: s = $sformatf("^%0d@%08h: *%08h <= %08h#", $urandom_range(999),
                       $urandom, $urandom, $urandom);
      default: s = $sformatf("^%0d@%0h: $1 <= 1#", $urandom_range(99),
                             $urandom_range(4095));
    endcase
    if ($urandom_range(3) == 0) begin
      k = $urandom_range(s.len() - 2, 1);
      push_str(src, s.substr(0, k - 1));
      if (src == 0) q0.push_back(GAP);
      else q1.push_back(GAP);
      push_str(src, s.substr(k, s.len() - 1));
    end else begin
      push_str(src, s);
    end
  endtask

  task automatic test_random();
    string hx = "0123456789abcdef";
    int n0, n1, nj;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      n0 = $urandom_range(5);
      n1 = $urandom_range(5);
      if (n0 + n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) add_random_rec(0, $urandom_range(2));
      for (int i = 0; i < n1; i++) add_random_rec(1, $urandom_range(2));
      if ($urandom_range(1) == 1) begin
        nj = $urandom_range(55, 1);
        for (int i = 0; i < nj; i++)
          q1.push_back({1'b0, hx[$urandom_range(15)]});
      end
      build_model();
      run_stream(4000);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_s1_types();
    test_round_robin();
    test_gap();
    test_overrun();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
